// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port arbiter in front of a single-port synchronous RAM.
//
// Purpose:
//   Shares one RAM port between a CPU data port (c_*) and a debug/display
//   port (d_*). At most one requester is granted per cycle. Grants are
//   combinational, so a lone request is granted in the cycle it is raised.
//   Read data returns one cycle after the grant. It is routed back using a
//   registered owner tag {valid, is_dbg}.
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : contention goes to the port that did
//                                       not own the previous grant.
//                           undefined : CPU always wins contention. The
//                                       last-owner register is still updated.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata  CPU request, write enable, address, write data
//   c_gnt/c_rvalid/c_rdata     CPU grant, read-data valid, read data
//   d_*                        debug port, same shape as c_*
//   m_en/m_we/m_addr/m_wdata   RAM strobe, write strobe, address, write data
//   m_rdata                    RAM read data, valid one cycle after a read
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_t;

    owner_t last_owner, next_owner;
    logic   tag_valid;
    logic   tag_dbg;

    // Grants are gated by rst_n so that no grant or strobe leaks out while
    // the block is held in reset.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (c_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (last_owner == OWNER_CPU) begin
                    d_gnt = 1'b1;
                end else begin
                    c_gnt = 1'b1;
                end
`else
                c_gnt = 1'b1;
`endif
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end
        end
    end

    always_comb begin
        m_en    = c_gnt | d_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    always_comb begin
        next_owner = last_owner;
        if (c_gnt) next_owner = OWNER_CPU;
        if (d_gnt) next_owner = OWNER_DBG;
    end

    // The tag is cleared asynchronously, so a read granted just before
    // reset never produces a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWNER_DBG;
            tag_valid  <= 1'b0;
            tag_dbg    <= 1'b0;
        end else begin
            last_owner <= next_owner;
            tag_valid  <= m_en & ~m_we;
            tag_dbg    <= d_gnt;
        end
    end

    always_comb begin
        c_rvalid = tag_valid & ~tag_dbg;
        d_rvalid = tag_valid & tag_dbg;
        c_rdata  = c_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width of RAM word and requester data buses.
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width of the shared RAM.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports c_req/c_we  input  1/1  CPU data-port request and write-enable.
REQ-006 SHALL have ports c_addr/c_wdata  input  ADDR_W/DATA_W  CPU address and write data.
REQ-007 SHALL have ports c_gnt/c_rvalid  output  1/1  CPU grant and read-data-valid.
REQ-008 SHALL have port c_rdata  output  DATA_W  CPU read data.
REQ-009 SHALL have ports d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata for the debug/display port, same directions and widths as the c_* ports.
REQ-010 SHALL have ports m_en/m_we  output  1/1  RAM access strobe and write strobe.
REQ-011 SHALL have ports m_addr/m_wdata  output  ADDR_W/DATA_W  RAM address and write data.
REQ-012 SHALL have port m_rdata  input  DATA_W  RAM read data, valid exactly one cycle after a read strobe.

Function
REQ-013 SHALL grant at most one requester per cycle; c_gnt and d_gnt never both 1.
REQ-014 SHALL compute grants combinationally from c_req, d_req and the priority state, so a lone request is granted in the cycle it is raised.
REQ-015 SHALL drive m_en=1 and m_we, m_addr and m_wdata from the granted requester in the grant cycle, and m_en=0, m_we=0 with no grant.
REQ-016 SHALL make a requester hold req, we, addr and wdata stable until it samples gnt=1; a request is complete in its gnt cycle.
REQ-017 SHALL register the owner tag {valid, is_dbg} for every granted read, and assert the matching x_rvalid for exactly one cycle in the next cycle.
REQ-018 SHALL drive x_rdata = m_rdata while x_rvalid=1, and 0 otherwise.
REQ-019 SHALL produce no rvalid for granted writes.
REQ-020 SHALL keep a 1-bit last-owner register, updated only on a grant, with 0=CPU and 1=DBG.
REQ-021 SHALL resolve simultaneous c_req and d_req by granting the port not equal to last-owner, with round-robin active.
REQ-022 SHALL sustain back-to-back grants every cycle; a grant overlapping the previous read's rvalid cycle is legal, and both responses are delivered in order.
REQ-023 SHALL ignore x_we, x_addr and x_wdata when x_req=0.

Reset
REQ-024 SHALL, while rst_n=0, force c_gnt, d_gnt, c_rvalid, d_rvalid, m_en and m_we to 0, and c_rdata and d_rdata to 0.
REQ-025 SHALL reset last-owner to 1 (DBG), so the CPU wins the first contention.
REQ-026 SHALL discard an in-flight read tag on reset assertion mid-operation; no rvalid is produced after rst_n deasserts.

Configuration
REQ-027 SHALL implement round-robin arbitration per REQ-021 when the macro MEM_ARB_ROUND_ROBIN_EN is defined.
REQ-028 SHALL, without MEM_ARB_ROUND_ROBIN_EN, use fixed priority in which the CPU always wins contention; last-owner is still maintained but unused.

Verification
REQ-029 SHALL test a lone CPU write: c_req=1, c_we=1, c_addr=5, c_wdata=0xDEADBEEF -> same cycle c_gnt=1, m_en=1, m_we=1, m_addr=5; no c_rvalid follows.
REQ-030 SHALL test a lone DBG read: d_req=1, d_we=0, d_addr=5 with RAM returning 0xDEADBEEF -> d_gnt=1 in cycle N; in cycle N+1 d_rvalid=1 and d_rdata=0xDEADBEEF, with c_rvalid=0.
REQ-031 SHALL test contention for 4 cycles with both reads held after reset, round-robin defined -> grant sequence C,D,C,D and rvalids alternating one cycle later.
REQ-032 SHALL test the same contention as REQ-031 without the macro -> C,C,C,C, with d_gnt=0 throughout.
REQ-033 SHALL test reset mid-read: rst_n=0 in the cycle after a c_gnt read -> c_rvalid stays 0 in that cycle and after release, and all outputs are 0 during reset.
REQ-034 SHALL test a CPU read at addr 7 followed next cycle by a DBG write at addr 7 -> c_rvalid occurs in the same cycle as d_gnt, and c_rdata returns the pre-write value.
